// File: rtl/gpio_pkg.sv
// Shared register map and sizing helpers for the Wishbone GPIO block.
package gpio_pkg;

    // Register word indexes (byte address bits [4:2]).
    localparam logic [2:0] GPIO_OUT  = 3'd0;
    localparam logic [2:0] GPIO_DIR  = 3'd1;
    localparam logic [2:0] GPIO_IN   = 3'd2;
    localparam logic [2:0] GPIO_EDGE = 3'd3;
    localparam logic [2:0] GPIO_IEN  = 3'd4;

    // Width of the debounce prescaler counting 0..div-1; never narrower than one bit.
    function automatic int unsigned deb_cnt_width(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input lane: 2-FF synchronizer, sample history and debounced level.
module gpio_debounce_bit #(
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic deb_o,
    output logic rise_o
);

    logic                   sync1_q, sync2_q;
    logic [DEB_SAMPLES-1:0] hist_q, hist_d;
    logic                   deb_q, deb_d;

    // On each tick shift in the synchronized sample; flip the level once the
    // whole history agrees on the opposite value. rise_o marks a 0->1 flip.
    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        rise_o = 1'b0;
        if (tick_i) begin
            hist_d = {hist_q[DEB_SAMPLES-2:0], sync2_q};
            if (hist_d == {DEB_SAMPLES{1'b1}} && !deb_q) begin
                deb_d  = 1'b1;
                rise_o = 1'b1;
            end else if (hist_d == {DEB_SAMPLES{1'b0}} && deb_q) begin
                deb_d = 1'b0;
            end
        end
    end

    // Synchronizer, history and debounced state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/wb_gpio_debounce.sv
// Wishbone classic GPIO slave with debounced inputs, rising-edge flags and a level IRQ.
module wb_gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEB_DIV     = 10000,
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    localparam int unsigned CntW = deb_cnt_width(DEB_DIV);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             tick;
    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, edge_q, edge_d, ien_q, ien_d;
    logic             ack_q, ack_d, irq_q, irq_d;
    logic [31:0]      dat_q, dat_d;
    logic [WIDTH-1:0] deb, rise;
    logic             req, wr;
    logic [2:0]       reg_idx;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask, wdat, rsel;
    logic             unused_bits;

    // Debounce sample prescaler: wraps at DEB_DIV-1 and ticks on that cycle.
    always_comb begin
        tick  = (cnt_q == CntW'(DEB_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_bit (
            .clk_i (wb_clk_i),
            .rst_i (wb_rst_i),
            .tick_i(tick),
            .raw_i (gpio_i[i]),
            .deb_o (deb[i]),
            .rise_o(rise[i])
        );
    end

    // Bus decode, register next-state and read mux.
    always_comb begin
        req     = wb_cyc_i & wb_stb_i & ~ack_q;
        wr      = req & wb_we_i;
        reg_idx = wb_adr_i[4:2];
        for (int k = 0; k < 4; k++) begin
            lane_mask[8*k +: 8] = {8{wb_sel_i[k]}};
        end
        wmask = lane_mask[WIDTH-1:0];
        wdat  = wb_dat_i[WIDTH-1:0];

        out_d = out_q;
        dir_d = dir_q;
        ien_d = ien_q;
        edge_d = edge_q;
        if (wr) begin
            case (reg_idx)
                GPIO_OUT:  out_d  = (out_q & ~wmask) | (wdat & wmask);
                GPIO_DIR:  dir_d  = (dir_q & ~wmask) | (wdat & wmask);
                GPIO_IEN:  ien_d  = (ien_q & ~wmask) | (wdat & wmask);
                GPIO_EDGE: edge_d = edge_q & ~(wdat & wmask);
                default:   ;
            endcase
        end
        // A new rise overrides a same-cycle W1C clear.
        edge_d = edge_d | rise;

        case (reg_idx)
            GPIO_OUT:  rsel = out_q;
            GPIO_DIR:  rsel = dir_q;
            GPIO_IN:   rsel = deb;
            GPIO_EDGE: rsel = edge_q;
            GPIO_IEN:  rsel = ien_q;
            default:   rsel = '0;
        endcase
        dat_d = '0;
        if (req) begin
            dat_d[WIDTH-1:0] = rsel;
        end

        ack_d = req;
        irq_d = |(edge_q & ien_q);
    end

    // All block state; synchronous reset also aborts an in-flight write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q  <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            edge_q <= '0;
            ien_q  <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            dir_q  <= dir_d;
            edge_q <= edge_d;
            ien_q  <= ien_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;
    assign irq_o    = irq_q;

    // Address byte offset and data/lane bits above WIDTH are intentionally ignored.
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, lane_mask};

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Directed bench for wb_gpio_debounce with DEB_DIV=4, DEB_SAMPLES=3, WIDTH=8.
module tb_wb_gpio_debounce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [7:0]  gpio_i = '0;
    logic [7:0]  gpio_o, gpio_oe;
    logic        irq_o;

    int n_vec = 0;
    int n_fail = 0;
    int tcnt = 0;

    wb_gpio_debounce #(
        .WIDTH(8),
        .DEB_DIV(4),
        .DEB_SAMPLES(3)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat),
        .wb_sel_i(wb_sel),
        .wb_we_i (wb_we),
        .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; prescaler ticks on edges where this becomes a multiple of 4.
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    typedef struct {
        logic        we;
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [7:0]  exp_o;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone transfer with strobe held through the ack cycle; checks ack is single-cycle.
    task automatic bus(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd);
        logic got;
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) got = 1'b1;
        end
        rd = wb_dat_o;
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack at adr 0x%02h", adr);
        end
        @(posedge clk); #1;
        chk($sformatf("ack_one_cycle_%02h", adr), {31'b0, wb_ack_o}, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int c0, t1, t3;

        vecs[0]  = '{1'b1, 5'h00, 32'h0000_00A5, 4'b0001, 32'h0,  8'hA5, 8'h00};
        vecs[1]  = '{1'b1, 5'h04, 32'h0000_00FF, 4'b0001, 32'h0,  8'hA5, 8'hFF};
        vecs[2]  = '{1'b1, 5'h00, 32'h0000_FF00, 4'b0010, 32'h0,  8'hA5, 8'hFF};
        vecs[3]  = '{1'b0, 5'h00, 32'h0,         4'b1111, 32'hA5, 8'hA5, 8'hFF};
        vecs[4]  = '{1'b0, 5'h04, 32'h0,         4'b1111, 32'hFF, 8'hA5, 8'hFF};
        vecs[5]  = '{1'b1, 5'h00, 32'h0000_005A, 4'b0000, 32'h0,  8'hA5, 8'hFF};
        vecs[6]  = '{1'b0, 5'h01, 32'h0,         4'b1111, 32'hA5, 8'hA5, 8'hFF};
        vecs[7]  = '{1'b1, 5'h10, 32'h1234_5601, 4'b1111, 32'h0,  8'hA5, 8'hFF};
        vecs[8]  = '{1'b0, 5'h10, 32'h0,         4'b1111, 32'h01, 8'hA5, 8'hFF};
        vecs[9]  = '{1'b1, 5'h14, 32'hFFFF_FFFF, 4'b1111, 32'h0,  8'hA5, 8'hFF};
        vecs[10] = '{1'b0, 5'h14, 32'h0,         4'b1111, 32'h0,  8'hA5, 8'hFF};
        vecs[11] = '{1'b1, 5'h04, 32'h0000_000F, 4'b1111, 32'h0,  8'hA5, 8'h0F};
        vecs[12] = '{1'b0, 5'h04, 32'h0,         4'b1111, 32'h0F, 8'hA5, 8'h0F};
        vecs[13] = '{1'b0, 5'h08, 32'h0,         4'b1111, 32'h0,  8'hA5, 8'h0F};
        vecs[14] = '{1'b1, 5'h08, 32'hFFFF_FFFF, 4'b1111, 32'h0,  8'hA5, 8'h0F};
        vecs[15] = '{1'b0, 5'h08, 32'h0,         4'b1111, 32'h0,  8'hA5, 8'h0F};
        vecs[16] = '{1'b0, 5'h0C, 32'h0,         4'b1111, 32'h0,  8'hA5, 8'h0F};
        vecs[17] = '{1'b0, 5'h1C, 32'h0,         4'b1111, 32'h0,  8'hA5, 8'h0F};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_gpio_o", {24'b0, gpio_o}, 32'h0);
        chk("rst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'b0, irq_o}, 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) begin
            bus(1'b0, 5'(a * 4), 32'h0, 4'hF, rd);
            chk($sformatf("rst_read_%02h", a * 4), rd, 32'h0);
        end

        // Register access table.
        for (int i = 0; i < 18; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_gpio_o", i), {24'b0, gpio_o}, {24'b0, vecs[i].exp_o});
            chk($sformatf("vec%0d_gpio_oe", i), {24'b0, gpio_oe}, {24'b0, vecs[i].exp_oe});
        end

        // Bit 0 steady rise with IEN=0x01: irq one cycle after the debounced rise.
        @(posedge clk); #1;
        gpio_i[0] = 1'b1;
        c0 = tcnt;
        t1 = ((c0 + 3 + 3) / 4) * 4;
        t3 = t1 + 8;
        for (int i = 0; i < 40 && !irq_o; i++) begin
            @(posedge clk); #1;
        end
        chk("b0_irq", {31'b0, irq_o}, 32'h1);
        chk("b0_irq_cycle", 32'(tcnt), 32'(t3 + 1));
        chk("b0_latency_le_15", {31'b0, (tcnt - c0) <= 15}, 32'h1);
        bus(1'b0, 5'h08, 32'h0, 4'hF, rd);
        chk("b0_in", rd, 32'h01);
        bus(1'b0, 5'h0C, 32'h0, 4'hF, rd);
        chk("b0_edge", rd, 32'h01);

        // W1C clear of EDGE[0]: irq holds in the ack cycle, drops the cycle after.
        wb_adr = 5'h0C; wb_dat = 32'h01; wb_sel = 4'b0001; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        chk("clr_ack", {31'b0, wb_ack_o}, 32'h1);
        chk("clr_irq_hold", {31'b0, irq_o}, 32'h1);
        @(posedge clk); #1;
        chk("clr_ack_low", {31'b0, wb_ack_o}, 32'h0);
        chk("clr_irq_drop", {31'b0, irq_o}, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;

        // 5-cycle glitch on bit 3 with IEN covering it must not register.
        bus(1'b1, 5'h10, 32'h0000_000D, 4'hF, rd);
        gpio_i[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        gpio_i[3] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("gl_irq", {31'b0, irq_o}, 32'h0);
        bus(1'b0, 5'h08, 32'h0, 4'hF, rd);
        chk("gl_in", rd, 32'h01);
        bus(1'b0, 5'h0C, 32'h0, 4'hF, rd);
        chk("gl_edge", rd, 32'h00);

        // Bit 2 debounced rise lands on the same edge as a W1C of 0x04: set wins.
        @(posedge clk); #1;
        gpio_i[2] = 1'b1;
        c0 = tcnt;
        t1 = ((c0 + 3 + 3) / 4) * 4;
        t3 = t1 + 8;
        for (int i = 0; i < 64 && tcnt != t3 - 1; i++) begin
            @(posedge clk); #1;
        end
        chk("b2_align", 32'(tcnt), 32'(t3 - 1));
        wb_adr = 5'h0C; wb_dat = 32'h04; wb_sel = 4'b0001; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        chk("b2_ack", {31'b0, wb_ack_o}, 32'h1);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        bus(1'b0, 5'h0C, 32'h0, 4'hF, rd);
        chk("b2_edge", rd, 32'h04);
        bus(1'b0, 5'h08, 32'h0, 4'hF, rd);
        chk("b2_in", rd, 32'h05);
        chk("b2_irq", {31'b0, irq_o}, 32'h1);

        // Reset lands on the edge that would ack a write of OUT=0x3C.
        @(posedge clk); #1;
        wb_adr = 5'h00; wb_dat = 32'h3C; wb_sel = 4'b0001; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_ack", {31'b0, wb_ack_o}, 32'h0);
        chk("mr_gpio_o", {24'b0, gpio_o}, 32'h0);
        chk("mr_gpio_oe", {24'b0, gpio_oe}, 32'h0);
        chk("mr_irq", {31'b0, irq_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        chk("mr_ack_idle", {31'b0, wb_ack_o}, 32'h0);
        bus(1'b0, 5'h00, 32'h0, 4'hF, rd);
        chk("mr_out", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
